// File: rtl/mem_pkg.sv
// Shared encodings and types for the data-memory access unit.
// Size codes, FSM states and the latched request bundle.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_t;

  // Size 11 is reserved and always rejected.
  function automatic logic bad_access(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      size == SZ_BYTE: bad = 1'b0;
      size == SZ_HALF: bad = off[0];
      size == SZ_WORD: bad = |off;
      default:         bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
// Purely combinational, little-endian lanes.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [31:0] b_shift;
  logic [31:0] h_shift;
  logic [31:0] b_mask;
  logic [31:0] h_mask;
  logic [7:0]  b_val;
  logic [15:0] h_val;

  always_comb begin
    b_shift = rdata >> {off, 3'b000};
    h_shift = rdata >> {off[1], 4'b0000};
    b_val   = b_shift[7:0];
    h_val   = h_shift[15:0];
    b_mask  = 32'h0000_00FF << {off, 3'b000};
    h_mask  = 32'h0000_FFFF << {off[1], 4'b0000};

    ld_data = rdata;
    st_data = wdata;
    unique case (1'b1)
      size == SZ_BYTE: begin
        ld_data = {{24{sign & b_val[7]}}, b_val};
        st_data = (rdata & ~b_mask)
                | ({4{wdata[7:0]}} & b_mask);
      end
      size == SZ_HALF: begin
        ld_data = {{16{sign & h_val[15]}}, h_val};
        st_data = (rdata & ~h_mask)
                | ({2{wdata[15:0]}} & h_mask);
      end
      default: begin
        ld_data = rdata;
        st_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle load/store unit driving a single-port word RAM.
// Sub-word stores are done as read-modify-write.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wren,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_END = CNT_W'(RD_LAT);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              ram_wren_q, ram_wren_d;

  logic        accept;
  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic        addr_hi_unused;

  assign addr_hi_unused = ^req_addr[31:ADDR_W+2];
  assign accept = req_valid & req_ready_q;

  mem_lane_align u_align (
    .off     (req_q.off),
    .size    (req_q.size),
    .sign    (req_q.sign),
    .wdata   (req_q.wdata),
    .rdata   (ram_rdata),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wren_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d.we    = req_we;
          req_d.size  = req_size;
          req_d.sign  = req_sign;
          req_d.off   = req_addr[1:0];
          req_d.wdata = req_wdata;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (bad_access(req_size, req_addr[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && req_size == SZ_WORD) begin
            state_d     = ST_WRITE;
            ram_addr_d  = req_addr[ADDR_W+1:2];
            ram_wdata_d = req_wdata;
            ram_wren_d  = 1'b1;
            rsp_valid_d = 1'b1;
          end else begin
            state_d    = ST_READ;
            ram_addr_d = req_addr[ADDR_W+1:2];
          end
        end
      end
      ST_READ: begin
        if (cnt_q == LAT_END) begin
          rsp_valid_d = 1'b1;
          if (req_q.we) begin
            state_d     = ST_WRITE;
            ram_wdata_d = st_data;
            ram_wren_d  = 1'b1;
          end else begin
            state_d     = ST_RESP;
            rsp_rdata_d = ld_data;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE, ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wren_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wren_q  <= ram_wren_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wren  = ram_wren_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a 1-cycle-latency RAM model.
// Expected values are hand-computed per step.
module tb_data_mem_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wren;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:1023];
  logic [9:0]  last_wa;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(10), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sign  (req_sign),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wren  (ram_wren),
    .ram_rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(
    input string       tag,
    input logic        we,
    input logic [1:0]  sz,
    input logic        sg,
    input logic [31:0] a,
    input logic [31:0] wd,
    input int          e_lat,
    input logic [31:0] e_rd,
    input logic        e_er,
    input int          e_nw
  );
    int lat;
    int nw;
    int wl;
    logic [31:0] rd;
    logic er;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_sign  = sg;
    req_addr  = a;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
    lat = 1;
    nw  = 0;
    wl  = 0;
    rd  = '0;
    er  = 1'b0;
    while (1) begin
      if (ram_wren) begin
        nw++;
        wl = lat;
        last_wa = ram_addr;
      end
      if (rsp_valid) begin
        rd = rsp_rdata;
        er = rsp_err;
        break;
      end
      if (lat >= 20) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout observed=none expected=rsp", tag);
        break;
      end
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_rdata"}, rd, e_rd);
    chk({tag, "_err"}, 32'(er), 32'(e_er));
    step();
    if (ram_wren) nw++;
    chk({tag, "_nwr"}, 32'(nw), 32'(e_nw));
    chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    if (e_nw > 0) chk({tag, "_wcyc"}, 32'(wl), 32'(e_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int nw;
    int lat;
    logic [31:0] rd;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = SZ_WORD;
    req_sign  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    last_wa   = '0;

    // 1 reset
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rvalid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    rst = 1'b1;
    step();

    // 2 word store / load
    run("sw10", 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF,
        1, 32'h0, 0, 1);
    chk("sw10_waddr", 32'(last_wa), 32'd4);
    chk("sw10_mem", mem[4], 32'hDEADBEEF);
    run("lw10", 0, SZ_WORD, 0, 32'h10, 32'h0,
        3, 32'hDEADBEEF, 0, 0);

    // 3 sub-word RMW and extraction
    run("sw10b", 1, SZ_WORD, 0, 32'h10, 32'h11223344,
        1, 32'h0, 0, 1);
    run("sb12", 1, SZ_BYTE, 0, 32'h12, 32'h000000AA,
        3, 32'h0, 0, 1);
    chk("sb12_mem", mem[4], 32'h11AA3344);
    run("lb12", 0, SZ_BYTE, 1, 32'h12, 32'h0,
        3, 32'hFFFFFFAA, 0, 0);
    run("lbu12", 0, SZ_BYTE, 0, 32'h12, 32'h0,
        3, 32'h000000AA, 0, 0);
    run("lh12", 0, SZ_HALF, 1, 32'h12, 32'h0,
        3, 32'h000011AA, 0, 0);
    run("lhu10", 0, SZ_HALF, 0, 32'h10, 32'h0,
        3, 32'h00003344, 0, 0);
    run("sh10", 1, SZ_HALF, 0, 32'h10, 32'h12348001,
        3, 32'h0, 0, 1);
    chk("sh10_mem", mem[4], 32'h11AA8001);
    run("lh10", 0, SZ_HALF, 1, 32'h10, 32'h0,
        3, 32'hFFFF8001, 0, 0);
    run("lb13", 0, SZ_BYTE, 1, 32'h13, 32'h0,
        3, 32'h00000011, 0, 0);
    run("lb11", 0, SZ_BYTE, 1, 32'h11, 32'h0,
        3, 32'hFFFFFF80, 0, 0);

    // 4 error responses
    run("lw13", 0, SZ_WORD, 0, 32'h13, 32'h0,
        1, 32'h0, 1, 0);
    run("lh11", 0, SZ_HALF, 1, 32'h11, 32'h0,
        1, 32'h0, 1, 0);
    run("sz11", 0, 2'b11, 0, 32'h10, 32'h0,
        1, 32'h0, 1, 0);
    run("sw12", 1, SZ_WORD, 0, 32'h12, 32'h55555555,
        1, 32'h0, 1, 0);
    run("sh13", 1, SZ_HALF, 0, 32'h13, 32'h5555,
        1, 32'h0, 1, 0);
    chk("err_mem", mem[4], 32'h11AA8001);

    // 5 reset during the read phase of an RMW
    run("sw20", 1, SZ_WORD, 0, 32'h20, 32'hCAFEF00D,
        1, 32'h0, 0, 1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SZ_HALF;
    req_sign  = 1'b0;
    req_addr  = 32'h22;
    req_wdata = 32'h1234;
    step();
    req_valid = 1'b0;
    chk("abort_busy", 32'(req_ready), 32'd0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    nv = 0;
    nw = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) nv++;
      if (ram_wren) nw++;
      step();
    end
    chk("abort_rsp", 32'(nv), 32'd0);
    chk("abort_wren", 32'(nw), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_mem", mem[8], 32'hCAFEF00D);

    // 6 held req_valid with changing fields; address wrap
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SZ_WORD;
    req_sign  = 1'b0;
    req_addr  = 32'h1000_0010;
    req_wdata = '0;
    step();
    chk("wrap_addr", 32'(ram_addr), 32'd4);
    chk("wrap_busy", 32'(req_ready), 32'd0);
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hBADBAD00;
    lat = 1;
    nw  = 0;
    rd  = '0;
    for (int i = 0; i < 10; i++) begin
      if (ram_wren) nw++;
      if (rsp_valid) begin
        rd = rsp_rdata;
        break;
      end
      req_addr = 32'h24 + 32'(i);
      step();
      lat++;
    end
    req_valid = 1'b0;
    chk("wrap_lat", 32'(lat), 32'd3);
    chk("wrap_rdata", rd, 32'h11AA8001);
    chk("wrap_wren", 32'(nw), 32'd0);
    step();
    chk("wrap_ready", 32'(req_ready), 32'd1);
    chk("wrap_mem8", mem[8], 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
